// File: rtl/branch_predict_table.sv
// 2-bit saturating-counter branch history table with misprediction flush/redirect and statistics.
// Latency: prediction is combinational; flush/redirect and statistics are registered one cycle after the resolving edge.
module branch_predict_table #(
    parameter int INDEX_BITS = 6,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           if_pc,
    output logic                  if_pred_taken,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_target,
    input  logic                  ex_taken,
    input  logic                  ex_pred_taken,
    output logic                  flush,
    output logic [31:0]           redirect_pc,
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]            ctr_q [ENTRIES];
    logic [1:0]            ex_ctr;
    logic [1:0]            ctr_d;
    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  mispredict;
    logic                  flush_q;
    logic [31:0]           redirect_q, redirect_d;
    logic [STAT_WIDTH-1:0] branches_q, branches_d;
    logic [STAT_WIDTH-1:0] mispredicts_q, mispredicts_d;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];

    // Reads see the registered array, so a same-cycle update is visible only next cycle.
    assign if_pred_taken = ctr_q[if_idx][1];
    assign ex_ctr        = ctr_q[ex_idx];
    assign mispredict    = ex_valid && (ex_taken != ex_pred_taken);

    always_comb begin
        ctr_d = ex_ctr;
        if (ex_taken) begin
            if (ex_ctr != 2'b11) ctr_d = ex_ctr + 2'd1;
        end else begin
            if (ex_ctr != 2'b00) ctr_d = ex_ctr - 2'd1;
        end
    end

    always_comb begin
        redirect_d = redirect_q;
        if (mispredict) redirect_d = ex_taken ? ex_target : (ex_pc + 32'd4);
    end

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (stat_clear) begin
            branches_d    = '0;
            mispredicts_d = '0;
        end else begin
            if (ex_valid && !(&branches_q))    branches_d    = branches_q + 1'b1;
            if (mispredict && !(&mispredicts_q)) mispredicts_d = mispredicts_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (ex_valid) begin
            ctr_q[ex_idx] <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            flush_q       <= mispredict;
            redirect_q    <= redirect_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign flush            = flush_q;
    assign redirect_pc      = redirect_q;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table; narrow statistics counters so saturation is reachable.
module tb_branch_predict_table;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   if_pc;
    logic          if_pred_taken;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [31:0]   ex_target;
    logic          ex_taken;
    logic          ex_pred_taken;
    logic          flush;
    logic [31:0]   redirect_pc;
    logic          stat_clear;
    logic [SW-1:0] stat_branches;
    logic [SW-1:0] stat_mispredicts;

    int n_checks = 0;
    int n_fails  = 0;

    branch_predict_table #(.INDEX_BITS(6), .STAT_WIDTH(SW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_taken         (ex_taken),
        .ex_pred_taken    (ex_pred_taken),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .stat_clear       (stat_clear),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One resolving cycle, then EX goes idle again.
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic pt);
        ex_valid = 1'b1; ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_pred_taken = pt;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        reset_n = 1'b0; if_pc = 32'h100; ex_valid = 1'b0; ex_pc = '0; ex_target = '0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0; stat_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;

        // Reset state
        check("reset_pred",  {31'd0, if_pred_taken}, 32'd0);
        check("reset_flush", {31'd0, flush}, 32'd0);
        check("reset_redir", redirect_pc, 32'd0);
        check("reset_br",    {28'd0, stat_branches}, 32'd0);
        check("reset_mp",    {28'd0, stat_mispredicts}, 32'd0);

        // Taken training at idx 0 (0x100): 01 -> 10 -> 11 -> 11, then one not-taken -> 10
        resolve(32'h100, 32'h0, 1'b1, 1'b1);
        pred_at("train1_pred", 32'h100, 1'b1);
        check("train1_flush", {31'd0, flush}, 32'd0);
        resolve(32'h100, 32'h0, 1'b1, 1'b1);
        resolve(32'h100, 32'h0, 1'b1, 1'b1);
        check("train3_br", {28'd0, stat_branches}, 32'd3);
        check("train3_flush", {31'd0, flush}, 32'd0);
        resolve(32'h100, 32'h0, 1'b0, 1'b0);
        pred_at("sat_hi_pred", 32'h100, 1'b1);

        // Low saturation at idx 2 (0x508): 01 -> 00 -> 00 -> 01 -> 10
        resolve(32'h508, 32'h0, 1'b0, 1'b0);
        resolve(32'h508, 32'h0, 1'b0, 1'b0);
        resolve(32'h508, 32'h0, 1'b1, 1'b1);
        pred_at("sat_lo_pred0", 32'h508, 1'b0);
        resolve(32'h508, 32'h0, 1'b1, 1'b1);
        pred_at("sat_lo_pred1", 32'h508, 1'b1);
        check("sat_lo_br", {28'd0, stat_branches}, 32'd8);
        check("no_mp_yet", {28'd0, stat_mispredicts}, 32'd0);

        // Taken mispredict: redirect to target, single-cycle pulse, redirect holds
        resolve(32'h200, 32'h180, 1'b1, 1'b0);
        check("mp_t_flush", {31'd0, flush}, 32'd1);
        check("mp_t_redir", redirect_pc, 32'h180);
        check("mp_t_cnt",   {28'd0, stat_mispredicts}, 32'd1);
        tick();
        check("mp_t_drop",  {31'd0, flush}, 32'd0);
        check("mp_t_hold",  redirect_pc, 32'h180);

        // Not-taken mispredict at top of address space: PC+4 wraps to 0
        resolve(32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1);
        check("wrap_flush", {31'd0, flush}, 32'd1);
        check("wrap_redir", redirect_pc, 32'h0);

        // Back-to-back mispredicts, each with its own redirect
        ex_valid = 1'b1; ex_pc = 32'h60C; ex_target = 32'h700; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        tick();
        check("b2b1_flush", {31'd0, flush}, 32'd1);
        check("b2b1_redir", redirect_pc, 32'h700);
        ex_pc = 32'h648; ex_target = 32'h660; ex_taken = 1'b0; ex_pred_taken = 1'b1;
        tick();
        ex_valid = 1'b0;
        check("b2b2_flush", {31'd0, flush}, 32'd1);
        check("b2b2_redir", redirect_pc, 32'h64C);
        check("b2b_mp",     {28'd0, stat_mispredicts}, 32'd4);
        check("b2b_br",     {28'd0, stat_branches}, 32'd12);

        // idx 0 is at 11 here; one not-taken -> 10, then read-before-write via alias 0x400
        resolve(32'h300, 32'h0, 1'b0, 1'b0);
        if_pc = 32'h300; ex_valid = 1'b1; ex_pc = 32'h400; ex_target = 32'h0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0;
        #1;
        check("rbw_pre",  {31'd0, if_pred_taken}, 32'd1);
        tick();
        ex_valid = 1'b0;
        check("rbw_post", {31'd0, if_pred_taken}, 32'd0);
        pred_at("alias_pred", 32'h400, 1'b0);

        // Branch counter saturates at all-ones (14 so far)
        resolve(32'h7F0, 32'h0, 1'b0, 1'b0);
        check("br_15", {28'd0, stat_branches}, 32'd15);
        resolve(32'h7F0, 32'h0, 1'b0, 1'b0);
        check("br_sat", {28'd0, stat_branches}, 32'd15);

        // Clear wins over a coincident mispredict increment
        stat_clear = 1'b1;
        resolve(32'h7F0, 32'h7A0, 1'b1, 1'b0);
        stat_clear = 1'b0;
        check("clr_br",    {28'd0, stat_branches}, 32'd0);
        check("clr_mp",    {28'd0, stat_mispredicts}, 32'd0);
        check("clr_flush", {31'd0, flush}, 32'd1);
        resolve(32'h7F0, 32'h7A0, 1'b0, 1'b1);
        check("after_clr_br", {28'd0, stat_branches}, 32'd1);
        check("after_clr_mp", {28'd0, stat_mispredicts}, 32'd1);

        // Reset in the middle of a flush pulse
        pred_at("pre_rst_pred", 32'h60C, 1'b1);
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redir", redirect_pc, 32'h0);
        check("rst_br",    {28'd0, stat_branches}, 32'd0);
        pred_at("rst_pred_60c", 32'h60C, 1'b0);
        pred_at("rst_pred_508", 32'h508, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_flush", {31'd0, flush}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
